keycode_action_decoder: RTL and testbench

//  Converts the raw 8-bit USB keycode from the Nios PIO into frame-synchronous player commands.

---
 rtl/keycode_action_decoder.sv | 122 ++++++++++++
 tb/tb_keycode_action_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/keycode_action_decoder.sv
// keycode_action_decoder: frame-synchronous movement, buffered jump and attack/cooldown commands from a HID keycode
module keycode_action_decoder #(
  parameter logic [7:0] KEY_LEFT        = 8'h04,
  parameter logic [7:0] KEY_RIGHT       = 8'h07,
  parameter logic [7:0] KEY_JUMP        = 8'h1A,
  parameter logic [7:0] KEY_ATTACK      = 8'h0D,
  parameter int         JUMP_BUF_FRAMES = 6,
  parameter int         ATK_ACT_FRAMES  = 8,
  parameter int         ATK_CD_FRAMES   = 20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_vs,
  input  logic [7:0] keycode,
  input  logic       jump_ack,
  output logic       frame_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       facing_left,
  output logic       jump_req,
  output logic       attack_active,
  output logic [3:0] action_status
);
  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} atk_t;
  localparam logic [3:0] JLOAD = 4'(JUMP_BUF_FRAMES);
  localparam logic [5:0] ALOAD = 6'(ATK_ACT_FRAMES - 1);
  localparam logic [5:0] CLOAD = 6'((ATK_CD_FRAMES == 0) ? 0 : ATK_CD_FRAMES - 1);
  atk_t       state, state_nxt;
  logic       vs_s1, vs_s2, vs_d, upd;
  logic [7:0] key_f, cur_key, prev_key;
  logic [3:0] jcnt;
  logic [5:0] acnt, acnt_nxt;
  logic       left_press, right_press, jump_press, atk_press;
  // unmapped codes are folded to "no key" so they never create presses
  assign key_f = (keycode == KEY_LEFT || keycode == KEY_RIGHT ||
                  keycode == KEY_JUMP || keycode == KEY_ATTACK) ? keycode : 8'h00;
  assign left_press  = cur_key == KEY_LEFT   && prev_key != KEY_LEFT;
  assign right_press = cur_key == KEY_RIGHT  && prev_key != KEY_RIGHT;
  assign jump_press  = cur_key == KEY_JUMP   && prev_key != KEY_JUMP;
  assign atk_press   = cur_key == KEY_ATTACK && prev_key != KEY_ATTACK;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
      upd        <= 1'b0;
      cur_key    <= 8'h00;
      prev_key   <= 8'h00;
    end else begin
      vs_s1      <= frame_vs;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      frame_tick <= vs_s2 & ~vs_d;
      upd        <= frame_tick;
      if (frame_tick) begin
        cur_key  <= key_f;
        prev_key <= cur_key;
      end
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      facing_left <= 1'b0;
    end else if (upd) begin
      move_left   <= cur_key == KEY_LEFT;
      move_right  <= cur_key == KEY_RIGHT;
      facing_left <= left_press ? 1'b1 : right_press ? 1'b0 : facing_left;
    end
  // a fresh press outranks a same-cycle ack so a re-press is never lost
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      jump_req <= 1'b0;
      jcnt     <= 4'd0;
    end else if (upd && jump_press) begin
      jump_req <= 1'b1;
      jcnt     <= JLOAD;
    end else if (jump_ack && jump_req) begin
      jump_req <= 1'b0;
      jcnt     <= 4'd0;
    end else if (upd && jcnt != 4'd0) begin
      jump_req <= jcnt != 4'd1;
      jcnt     <= jcnt - 4'd1;
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      acnt  <= 6'd0;
    end else begin
      state <= state_nxt;
      acnt  <= acnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    acnt_nxt  = acnt;
    if (upd)
      case (state)
        IDLE: if (atk_press) begin
          state_nxt = ACTIVE;
          acnt_nxt  = ALOAD;
        end
        ACTIVE: if (acnt == 6'd0) begin
          state_nxt = (ATK_CD_FRAMES == 0) ? IDLE : COOLDOWN;
          acnt_nxt  = CLOAD;
        end else acnt_nxt = acnt - 6'd1;
        COOLDOWN: if (acnt == 6'd0) state_nxt = IDLE;
          else acnt_nxt = acnt - 6'd1;
        default: begin
          state_nxt = IDLE;
          acnt_nxt  = 6'd0;
        end
      endcase
  end
  always_comb begin
    attack_active = state == ACTIVE;
    action_status = (state == ACTIVE)          ? 4'd3 :
                    (state == COOLDOWN)        ? 4'd4 :
                    jump_req                   ? 4'd2 :
                    (move_left | move_right)   ? 4'd1 : 4'd0;
  end
endmodule

// File: tb/tb_keycode_action_decoder.sv
// tb_keycode_action_decoder: directed checks of tick timing, movement, jump buffer and attack FSM
module tb_keycode_action_decoder;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_vs = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       jump_ack = 1'b0;
  logic       frame_tick, move_left, move_right, facing_left, jump_req, attack_active;
  logic [3:0] action_status;
  int tests = 0, fails = 0, ticks = 0, nframes = 0, t0;
  keycode_action_decoder dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .keycode(keycode), .jump_ack(jump_ack),
    .frame_tick(frame_tick), .move_left(move_left), .move_right(move_right),
    .facing_left(facing_left), .jump_req(jump_req), .attack_active(attack_active),
    .action_status(action_status)
  );
  always #10 Clk = ~Clk;
  always @(posedge Clk) if (frame_tick) ticks++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic frame();
    frame_vs = 1'b0;
    repeat (4) @(posedge Clk);
    #1 frame_vs = 1'b1;
    nframes++;
    repeat (8) @(posedge Clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("reset_outputs", {frame_tick, move_left, move_right, facing_left, jump_req, attack_active}, 0);
    check("reset_status", action_status, 0);
    Reset_n = 1'b1;
    frame();
    frame();
    // tick timing: none on the falling edge, one pulse 3 Clk after the rising edge
    t0 = ticks;
    @(posedge Clk);
    #1 frame_vs = 1'b0;
    repeat (6) @(posedge Clk);
    #1 check("no_tick_on_fall", ticks, t0);
    frame_vs = 1'b1;
    nframes++;
    @(posedge Clk); #1 check("tick_lat1", frame_tick, 0);
    @(posedge Clk); #1 check("tick_lat2", frame_tick, 0);
    @(posedge Clk); #1 check("tick_lat3", frame_tick, 1);
    @(posedge Clk); #1 check("tick_width", frame_tick, 0);
    check("tick_count", ticks, t0 + 1);
    repeat (6) @(posedge Clk);
    #1;
    // movement
    keycode = 8'h04;
    for (int i = 0; i < 3; i++) begin
      frame();
      check("move_left_held", move_left, 1);
      check("facing_left_set", facing_left, 1);
      check("status_run", action_status, 1);
    end
    keycode = 8'h00;
    frame();
    check("move_left_release", move_left, 0);
    check("facing_left_holds", facing_left, 1);
    check("status_idle", action_status, 0);
    keycode = 8'h07;
    frame();
    check("move_right", move_right, 1);
    check("facing_right", facing_left, 0);
    keycode = 8'h55;
    frame();
    check("unmapped_no_move", {move_left, move_right}, 0);
    check("unmapped_status", action_status, 0);
    keycode = 8'h00;
    frame();
    // jump buffer expiry: pending for exactly 6 frames
    keycode = 8'h1A;
    frame();
    check("jump_req_set", jump_req, 1);
    check("status_jump", action_status, 2);
    keycode = 8'h00;
    for (int i = 0; i < 5; i++) begin
      frame();
      check("jump_req_pending", jump_req, 1);
    end
    frame();
    check("jump_req_expired", jump_req, 0);
    // jump ack
    keycode = 8'h1A;
    frame();
    repeat (90) @(posedge Clk);
    #1 check("jump_req_before_ack", jump_req, 1);
    jump_ack = 1'b1;
    @(posedge Clk);
    #1 jump_ack = 1'b0;
    check("jump_req_acked", jump_req, 0);
    jump_ack = 1'b1;
    @(posedge Clk);
    #1 jump_ack = 1'b0;
    check("ack_when_idle", jump_req, 0);
    keycode = 8'h00;
    frame();
    check("jump_stays_clear", jump_req, 0);
    // attack held: 8 active, 20 cooldown, no re-trigger
    keycode = 8'h0D;
    for (int k = 1; k <= 40; k++) begin
      frame();
      check("atk_held_active", attack_active, (k <= 8) ? 1 : 0);
      check("atk_held_status", action_status, (k <= 8) ? 3 : (k <= 28) ? 4 : 0);
    end
    keycode = 8'h00;
    frame();
    check("atk_idle_after", action_status, 0);
    // press during cooldown is dropped
    for (int k = 1; k <= 30; k++) begin
      keycode = (k == 1 || k == 13) ? 8'h0D : 8'h00;
      frame();
      check("atk_cd_press_status", action_status, (k <= 8) ? 3 : (k <= 28) ? 4 : 0);
    end
    // async reset mid-ACTIVE
    keycode = 8'h0D;
    frame();
    check("atk_restart", attack_active, 1);
    keycode = 8'h00;
    frame();
    @(posedge Clk);
    #7 Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {frame_tick, move_left, move_right, facing_left, jump_req, attack_active}, 0);
    check("async_reset_status", action_status, 0);
    #25 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    frame();
    check("post_reset_idle", action_status, 0);
    keycode = 8'h0D;
    frame();
    check("post_reset_press", attack_active, 1);
    check("post_reset_status", action_status, 3);
    keycode = 8'h00;
    check("total_ticks", ticks, nframes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
